// File: rtl/motor_pkg.sv
// Shared types and default timing constants for the motor PWM driver.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_DEAD = 2'd3
  } motor_state_e;

  localparam int PERIOD_DEF       = 100;
  localparam int RAMP_STEP_DEF    = 5;
  localparam int DEAD_PERIODS_DEF = 2;

endpackage

// File: rtl/motor_pwm_driver_tick_sync.sv
// Brings the divided motor clock into the system clock domain and emits one
// system-clock pulse per rising edge of it.
module tick_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // A level held high only produces a pulse on the cycle it first appears.
  assign o_tick = r_sync2 & ~r_hist;

endmodule

// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: tick-driven period counter, ramped duty, and a
// ramp-down / dead-time sequence before any direction reversal.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PERIOD       = PERIOD_DEF,
  parameter int RAMP_STEP    = RAMP_STEP_DEF,
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEF,
  parameter int DUTY_W       = $clog2(PERIOD + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_tick_clk,
  input  logic              i_enable,
  input  logic              i_dir,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_pwm,
  output logic              o_dir,
  output logic [DUTY_W-1:0] o_duty_cur,
  output logic              o_busy
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] PERIOD_D  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

  logic               w_tick;
  logic               w_wrap;
  logic [DUTY_W-1:0]  w_tgt;

  logic [CNT_W-1:0]   r_cnt;
  motor_state_e       r_state;
  logic [DEAD_W-1:0]  r_dead_cnt;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_dir;
  logic               r_pwm;

  // One RAMP_STEP toward the target, never overshooting it in either direction.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    logic [DUTY_W:0] cur_x;
    logic [DUTY_W:0] tgt_x;
    logic [DUTY_W:0] up_x;
    logic [DUTY_W:0] dn_x;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    up_x  = cur_x + STEP_X;
    dn_x  = cur_x - STEP_X;
    if (cur_x < tgt_x) begin
      step_toward = (up_x > tgt_x) ? tgt : up_x[DUTY_W-1:0];
    end else if (cur_x > tgt_x) begin
      step_toward = (cur_x > (tgt_x + STEP_X)) ? dn_x[DUTY_W-1:0] : tgt;
    end else begin
      step_toward = cur;
    end
  endfunction

  function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] cur);
    logic [DUTY_W:0] cur_x;
    logic [DUTY_W:0] dn_x;
    cur_x = {1'b0, cur};
    dn_x  = cur_x - STEP_X;
    step_down = (cur_x > STEP_X) ? dn_x[DUTY_W-1:0] : '0;
  endfunction

  tick_sync u_tick_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_tick_clk),
    .o_tick    (w_tick)
  );

  assign w_wrap = w_tick && (r_cnt == CNT_MAX);
  assign w_tgt  = (i_duty > PERIOD_D) ? PERIOD_D : i_duty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_dead_cnt <= '0;
      r_duty     <= '0;
      r_dir      <= 1'b0;
      r_pwm      <= 1'b0;
    end else begin
      r_pwm <= ((r_state == ST_RUN) || (r_state == ST_STOP)) &&
               (DUTY_W'(r_cnt) < r_duty);
      unique case (r_state)
        ST_IDLE: begin
          r_duty     <= '0;
          r_dead_cnt <= '0;
          if (i_enable) begin
            r_dir   <= i_dir;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Exit wins over the ramp: a stop requested on a wrap steps down.
          if (!i_enable || (i_dir != r_dir)) begin
            r_state <= ST_STOP;
            if (w_wrap) begin
              r_duty <= step_down(r_duty);
            end
          end else if (w_wrap) begin
            r_duty <= step_toward(r_duty, w_tgt);
          end
        end
        ST_STOP: begin
          if (w_wrap) begin
            if (i_enable && (i_dir == r_dir)) begin
              r_state <= ST_RUN;
            end else if (r_duty == '0) begin
              r_state    <= ST_DEAD;
              r_dead_cnt <= '0;
            end else begin
              r_duty <= step_down(r_duty);
            end
          end
        end
        ST_DEAD: begin
          if (w_wrap) begin
            if (r_dead_cnt == DEAD_LAST) begin
              r_dead_cnt <= '0;
              if (i_enable) begin
                r_dir   <= i_dir;
                r_state <= ST_RUN;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_dead_cnt <= r_dead_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pwm      = r_pwm;
  assign o_dir      = r_dir;
  assign o_duty_cur = r_duty;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: expected duty steps are queued by the
// stimulus and popped by a monitor whenever o_duty_cur changes.
module tb_motor_pwm_driver;

  localparam int DUTY_W = 7;
  localparam int PCYC   = 400;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_tick_clk;
  logic              i_enable;
  logic              i_dir;
  logic [DUTY_W-1:0] i_duty;
  logic              o_pwm;
  logic              o_dir;
  logic [DUTY_W-1:0] o_duty_cur;
  logic              o_busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   exp_q[$];
  bit   mon_en   = 1'b0;
  bit   tick_run = 1'b0;
  bit   tick_man = 1'b0;

  motor_pwm_driver dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_tick_clk (i_tick_clk),
    .i_enable   (i_enable),
    .i_dir      (i_dir),
    .i_duty     (i_duty),
    .o_pwm      (o_pwm),
    .o_dir      (o_dir),
    .o_duty_cur (o_duty_cur),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  // Divided clock: 4 system cycles per tick when running, else manual level.
  initial begin
    bit gen;
    int div;
    gen = 1'b0;
    div = 0;
    i_tick_clk = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (tick_run) begin
        div = div + 1;
        if (div == 2) begin
          div = 0;
          gen = ~gen;
        end
      end
      i_tick_clk = tick_run ? gen : tick_man;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    logic [DUTY_W-1:0] prev_duty;
    logic              prev_dir;
    int                e;
    prev_duty = '0;
    prev_dir  = 1'b0;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        if (o_duty_cur !== prev_duty) begin
          if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL duty_unexpected: got %0d, expected no change from %0d",
                     o_duty_cur, prev_duty);
          end else begin
            e = exp_q.pop_front();
            check("duty_step", int'(o_duty_cur), e);
          end
        end
        if (i_reset_n && (o_dir !== prev_dir))
          check("pwm_at_dir_change", int'(o_pwm), 0);
      end
      prev_duty = o_duty_cur;
      prev_dir  = o_dir;
    end
  end

  task automatic push_ramp(input int from, input int to, input int step);
    if (from <= to) begin
      for (int v = from; v <= to; v += step) exp_q.push_back(v);
    end else begin
      for (int v = from; v >= to; v -= step) exp_q.push_back(v);
    end
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge i_clk);
      n = n + 1;
    end
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: %0d steps still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic measure(input string name, input int exp_hi);
    int hi;
    hi = 0;
    repeat (PCYC) begin
      @(negedge i_clk);
      if (o_pwm) hi = hi + 1;
    end
    check(name, hi, exp_hi);
  endtask

  initial begin
    int t0;
    int hi;
    int n;
    i_reset_n = 1'b0;
    i_enable  = 1'b0;
    i_dir     = 1'b0;
    i_duty    = '0;
    repeat (3) @(posedge i_clk);
    #2;
    check("rst_pwm",  int'(o_pwm), 0);
    check("rst_dir",  int'(o_dir), 0);
    check("rst_duty", int'(o_duty_cur), 0);
    check("rst_busy", int'(o_busy), 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    mon_en    = 1'b1;

    // Held tick level: counter moves once, three edges after the rise.
    @(negedge i_clk);
    tick_man = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    check("tick_lat_2edges", int'(dut.r_cnt), 0);
    @(posedge i_clk);
    #2;
    check("tick_lat_3edges", int'(dut.r_cnt), 1);
    repeat (500) @(posedge i_clk);
    #2;
    check("tick_held_once", int'(dut.r_cnt), 1);
    tick_man = 1'b0;
    repeat (5) @(posedge i_clk);
    tick_run = 1'b1;

    // Ramp-up to 20
    @(negedge i_clk);
    i_duty   = 7'd20;
    i_dir    = 1'b1;
    i_enable = 1'b1;
    push_ramp(5, 20, 5);
    @(posedge i_clk);
    #2;
    check("busy_after_enable", int'(o_busy), 1);
    check("dir_after_enable",  int'(o_dir), 1);
    wait_sb("ramp_up", 4 * PCYC + 1000);
    repeat (10) @(negedge i_clk);
    measure("pwm_high_duty20", 80);

    // Clamp to full scale, then down to zero
    i_duty = 7'd127;
    push_ramp(25, 100, 5);
    wait_sb("clamp", 16 * PCYC + 1000);
    repeat (10) @(negedge i_clk);
    measure("pwm_high_full", PCYC);
    check("duty_clamped", int'(o_duty_cur), 100);
    i_duty = 7'd0;
    push_ramp(95, 0, 5);
    wait_sb("ramp_zero", 20 * PCYC + 1000);
    repeat (10) @(negedge i_clk);
    measure("pwm_high_zero", 0);

    // Reversal at duty 20
    i_duty = 7'd20;
    push_ramp(5, 20, 5);
    wait_sb("rev_up", 4 * PCYC + 1000);
    @(negedge i_clk);
    i_dir = 1'b0;
    push_ramp(15, 0, 5);
    wait_sb("rev_down", 4 * PCYC + 1000);
    t0 = cyc;
    hi = 0;
    n  = 0;
    while ((o_dir !== 1'b0) && (n < 5 * PCYC)) begin
      @(negedge i_clk);
      if (o_pwm) hi = hi + 1;
      n = n + 1;
    end
    check("rev_dir_flipped", int'(o_dir), 0);
    check("rev_pwm_dead", hi, 0);
    check("rev_dead_time", int'((cyc - t0 >= 3 * PCYC - 10) && (cyc - t0 <= 3 * PCYC + 10)), 1);
    push_ramp(5, 20, 5);
    wait_sb("rev_reramp", 4 * PCYC + 1000);

    // Disable at duty 12
    i_duty = 7'd12;
    push_ramp(15, 12, 3);
    wait_sb("to_12", 2 * PCYC + 1000);
    @(negedge i_clk);
    i_enable = 1'b0;
    exp_q.push_back(7);
    exp_q.push_back(2);
    exp_q.push_back(0);
    wait_sb("disable_down", 3 * PCYC + 1000);
    t0 = cyc;
    hi = 0;
    n  = 0;
    while ((o_busy !== 1'b0) && (n < 5 * PCYC)) begin
      @(negedge i_clk);
      if (o_pwm) hi = hi + 1;
      n = n + 1;
    end
    check("disable_idle", int'(o_busy), 0);
    check("disable_pwm_dead", hi, 0);
    check("disable_dead_time", int'((cyc - t0 >= 3 * PCYC - 10) && (cyc - t0 <= 3 * PCYC + 10)), 1);
    check("disable_dir_held", int'(o_dir), 0);

    // Reset while the output is high
    @(negedge i_clk);
    i_duty   = 7'd20;
    i_dir    = 1'b1;
    i_enable = 1'b1;
    push_ramp(5, 20, 5);
    wait_sb("pre_reset", 4 * PCYC + 1000);
    n = 0;
    while ((o_pwm !== 1'b1) && (n < PCYC)) begin
      @(negedge i_clk);
      n = n + 1;
    end
    check("pwm_high_before_reset", int'(o_pwm), 1);
    @(posedge i_clk);
    #2;
    exp_q.push_back(0);
    i_enable  = 1'b0;
    i_reset_n = 1'b0;
    #1;
    check("async_rst_pwm",  int'(o_pwm), 0);
    check("async_rst_duty", int'(o_duty_cur), 0);
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_dir",  int'(o_dir), 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (PCYC) @(negedge i_clk);
    check("post_reset_idle", int'(o_busy), 0);
    check("post_reset_pwm",  int'(o_pwm), 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
